// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the bridge (master) and one register responder (slave).
// A transfer is a setup cycle (Psel=1, Penable=0), then access cycles (Psel=1, Penable=1); it completes on the edge where Pready=1.
interface apb_reg_slave_if;
   logic        Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        Pready;
   logic        Pslverr;

   modport master (
      output Psel, Penable, Pwrite, Paddr, Pwdata,
      input  Prdata, Pready, Pslverr
   );

   modport slave (
      input  Psel, Penable, Pwrite, Paddr, Pwdata,
      output Prdata, Pready, Pslverr
   );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register bank: read-only ID at index 0, read/write registers above it,
// programmable wait states and error response; register 1 is exported as ctrl_out.
module apb_reg_slave #(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   apb_reg_slave_if.slave     bus,
   output logic [31:0]        ctrl_out,
   output logic               dbg_state
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [5:0]  addr_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] regs [16];

   logic        latch;
   logic        commit;
   logic        err_setup;
   logic [3:0]  idx_q;
   logic [31:0] rd_val;
   logic        unused_addr;

   assign unused_addr = ^bus.Paddr[31:6];
   assign idx_q       = addr_q[5:2];
   assign dbg_state   = state;
   assign ctrl_out    = regs[1];

   // Error is decided from the setup-phase bus values and held for the whole transfer.
   assign err_setup = (bus.Paddr[1:0] != 2'b00) ||
                      (32'(bus.Paddr[5:2]) >= NUM_REGS) ||
                      (bus.Pwrite && (bus.Paddr[5:2] == 4'd0));

   assign rd_val = (idx_q == 4'd0) ? ID_VALUE : regs[idx_q];

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      latch       = 1'b0;
      commit      = 1'b0;
      bus.Pready  = 1'b0;
      bus.Pslverr = 1'b0;
      bus.Prdata  = 32'd0;
      case (state)
         S_IDLE: begin
            if (bus.Psel && !bus.Penable) begin
               state_nxt = S_ACCESS;
               latch     = 1'b1;
               cnt_nxt   = 3'(WAIT_STATES);
            end
         end
         S_ACCESS: begin
            if (!bus.Psel) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 3'd0;
            end else if (!bus.Penable) begin
               // A fresh setup while in access replaces the pending transfer.
               latch   = 1'b1;
               cnt_nxt = 3'(WAIT_STATES);
            end else if (cnt != 3'd0) begin
               cnt_nxt = cnt - 3'd1;
            end else begin
               bus.Pready  = 1'b1;
               bus.Pslverr = err_q;
               bus.Prdata  = (!write_q && !err_q) ? rd_val : 32'd0;
               commit      = write_q && !err_q;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         addr_q  <= 6'd0;
         write_q <= 1'b0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (latch) begin
            addr_q  <= bus.Paddr[5:0];
            write_q <= bus.Pwrite;
            wdata_q <= bus.Pwdata;
            err_q   <= err_setup;
         end
      end
   end

   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      end else begin
         for (int i = 1; i < 16; i++) begin
            if (commit && (idx_q == 4'(i)) && (i < NUM_REGS)) regs[i] <= wdata_q;
         end
      end
   end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB responder terminating one `Pselx` line driven by the AHB-to-APB bridge FSM. It implements a bank of 32-bit registers with a configurable number of wait states. Error signalling covers misaligned addresses, out-of-range addresses and writes to the read-only ID register. Register 1 is exported as a control word to downstream logic.

## Interface
Parameters:
- `NUM_REGS`, 16: number of implemented registers, 2..16; index = `Paddr[5:2]`.
- `WAIT_STATES`, 0: extra access cycles before `Pready`, 0..7.
- `ID_VALUE`, 32'hA2B0_0001: constant returned by register 0.

Ports:
- `Hclk` input 1: single clock; all state changes on its rising edge.
- `Hresetn` input 1: reset, synchronous, active-low.
- `Psel` input 1: this slave's bit of the bridge `Pselx`.
- `Penable` input 1: APB enable (access phase).
- `Pwrite` input 1: 1 = write, 0 = read.
- `Paddr` input 32: byte address; only `[5:0]` decoded, `[31:6]` ignored.
- `Pwdata` input 32: write data.
- `Prdata` output 32: read data, valid only when `Pready`=1 on a read, else 0.
- `Pready` output 1: transfer completes this cycle.
- `Pslverr` output 1: transfer error, valid only when `Pready`=1, else 0.
- `ctrl_out` output 32: current value of register 1.

## Operation
- Registers: index 0 is read-only and reads `ID_VALUE`; indices 1..`NUM_REGS`-1 are read/write and reset to 0.
- The FSM has two states.
  - IDLE: waits for a setup cycle.
  - ACCESS: serves the access phase.
- IDLE -> ACCESS: on an edge with `Psel`=1, `Penable`=0.
  - Latch `Paddr[5:0]`, `Pwrite` and `Pwdata`.
  - Load the wait counter `cnt` with `WAIT_STATES`.
  - Compute and latch `err`.
- `err` = 1 when any of these holds:
  - `Paddr[1:0]` != 0;
  - index >= `NUM_REGS`;
  - a write to index 0.
- ACCESS, `Psel`=1, `Penable`=1, `cnt`!=0: `cnt` decrements and the FSM stays in ACCESS.
- ACCESS, `Psel`=1, `Penable`=1, `cnt`=0: `Pready`=1.
  - At the edge, a write with `err`=0 commits the latched data to the latched index.
  - The FSM returns to IDLE.
- ACCESS, `Psel`=0 (protocol abort): the FSM returns to IDLE. No write occurs, `Pready` stays 0 and no error is flagged.
- ACCESS, `Psel`=1, `Penable`=0 (illegal restart): treated as a new setup. Relatch the transfer, reload `cnt`, stay in ACCESS, and do not commit the old transfer.
- IDLE, `Psel`=1, `Penable`=1 without a preceding setup: ignored. `Pready`=0 and there is no side effect.
- Read data:
  - `Prdata` = register[latched index] when `Pready`=1, the transfer is a read and `err`=0.
  - Otherwise `Prdata` = 0. This includes erroring reads, which return 0.
- Write data uses the value latched at setup; `Pwdata` changes during the access phase are ignored.
- `ctrl_out` always reflects register 1. It updates the cycle after the committing edge.

## Timing
- Reset (`Hresetn`=0 at an edge):
  - State = IDLE, `cnt` = 0, all RW registers = 0.
  - `Pready` = 0, `Pslverr` = 0, `Prdata` = 0, `ctrl_out` = 0.
  - Reset asserted mid-transfer discards the transfer and performs no write.
- `Pready`, `Pslverr` and `Prdata` are combinational from state, `cnt` and the latched fields. They have no combinational path from `Paddr` or `Pwdata`.
- Transfer latency is 2 + `WAIT_STATES` cycles, counted from the setup edge to the completing edge inclusive. With `WAIT_STATES`=0, `Pready` is 1 in the first access cycle, which matches the bridge's fixed two-cycle transfer.
- Back-to-back transfers: the cycle after a completing edge may be a new setup cycle. IDLE accepts it with no bubble.
- Write visibility: a read of the same index in the next transfer returns the new value.

## Test plan
- Reset then idle: `Hresetn`=0 for 2 cycles, then 1 -> all outputs 0 and `ctrl_out`=0; a read of index 0 returns 32'hA2B0_0001 with `Pslverr`=0.
- Write then read, `WAIT_STATES`=0: write 32'hDEAD_BEEF to `Paddr`=0x04 -> `Pready`=1 in the access cycle and `ctrl_out`=32'hDEAD_BEEF on the next cycle; a read of 0x04 returns 32'hDEAD_BEEF.
- Wait states, `WAIT_STATES`=3: read 0x08 -> `Pready` is 0 for 3 access cycles and 1 on the 4th; total transfer is 5 cycles.
- Errors:
  - Write to 0x00 -> `Pslverr`=1 and the ID is unchanged.
  - Write to 0x06 (misaligned) -> `Pslverr`=1 and no register changes.
  - With `NUM_REGS`=4, read 0x10 -> `Pslverr`=1 and `Prdata`=0.
- Abort: setup write 32'h1234_5678 to 0x04, then drop `Psel` during the access phase with `WAIT_STATES`=2 -> FSM returns to IDLE, register 1 is unchanged and `Pready` is never 1.
- Reset mid-access: assert `Hresetn`=0 during a wait-state cycle of a write to 0x0C -> register 3 reads 0 after reset and no `Pready` is produced.
